// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: register-write front end, shared prescaler and period counter,
// double-buffered per-channel duty with static-level override.
module pwm_bank #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned PRE_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ena,
  input  logic              i_reg_wr_en,
  input  logic [3:0]        i_reg_addr,
  input  logic [CNT_W-1:0]  i_reg_wdata,
  output logic [CNT_W-1:0]  o_reg_rdata,
  output logic [NUM_CH-1:0] o_pwm_out,
  output logic              o_period_tick
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [NUM_CH-1:0] r_en;
  logic [NUM_CH-1:0] r_mode;
  logic [NUM_CH-1:0] r_level;
  logic [PRE_W-1:0]  r_pre;
  logic [PRE_W-1:0]  r_pre_cnt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_duty     [NUM_CH];
  logic [CNT_W-1:0]  r_duty_act [NUM_CH];
  logic [NUM_CH-1:0] r_pwm;
  logic              r_tick;

  logic              w_step;
  logic              w_boundary;
  logic [NUM_CH-1:0] w_pwm_d;

  assign w_step     = i_ena && (r_pre_cnt == r_pre);
  assign w_boundary = w_step && (r_cnt == CntMax);

  // Writes are accepted regardless of i_ena.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_en    <= '0;
      r_mode  <= '0;
      r_level <= '0;
      r_pre   <= '0;
      for (int k = 0; k < NUM_CH; k++) r_duty[k] <= '0;
    end else if (i_reg_wr_en) begin
      case (i_reg_addr)
        4'h0:    r_en    <= i_reg_wdata[NUM_CH-1:0];
        4'h1:    r_mode  <= i_reg_wdata[NUM_CH-1:0];
        4'h2:    r_level <= i_reg_wdata[NUM_CH-1:0];
        4'h3:    r_pre   <= i_reg_wdata[PRE_W-1:0];
        default: ;
      endcase
      for (int k = 0; k < NUM_CH; k++) begin
        if (i_reg_addr == 4'(k + 4)) r_duty[k] <= i_reg_wdata;
      end
    end
  end

  // Shadow-to-active copy samples the pre-write shadow when a write hits the boundary cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pre_cnt <= '0;
      r_cnt     <= '0;
      r_tick    <= 1'b0;
      r_pwm     <= '0;
      for (int k = 0; k < NUM_CH; k++) r_duty_act[k] <= '0;
    end else begin
      r_tick <= w_boundary;
      r_pwm  <= w_pwm_d;
      if (i_ena) r_pre_cnt <= w_step ? '0 : r_pre_cnt + 1'b1;
      if (w_step) r_cnt <= r_cnt + 1'b1;
      if (w_boundary) begin
        for (int k = 0; k < NUM_CH; k++) r_duty_act[k] <= r_duty[k];
      end
    end
  end

  always_comb begin
    w_pwm_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!i_ena || !r_en[k]) begin
        w_pwm_d[k] = 1'b0;
      end else if (!r_mode[k]) begin
        w_pwm_d[k] = r_level[k];
      end else if (r_duty_act[k] == CntMax) begin
        w_pwm_d[k] = 1'b1;
      end else begin
        w_pwm_d[k] = (r_cnt < r_duty_act[k]);
      end
    end
  end

  always_comb begin
    o_reg_rdata = '0;
    case (i_reg_addr)
      4'h0:    o_reg_rdata[NUM_CH-1:0] = r_en;
      4'h1:    o_reg_rdata[NUM_CH-1:0] = r_mode;
      4'h2:    o_reg_rdata[NUM_CH-1:0] = r_level;
      4'h3:    o_reg_rdata[PRE_W-1:0]  = r_pre;
      default: begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (i_reg_addr == 4'(k + 4)) o_reg_rdata = r_duty[k];
        end
      end
    endcase
  end

  assign o_pwm_out     = r_pwm;
  assign o_period_tick = r_tick;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: reset, PWM duty, extremes, static mode, double-buffering,
// prescaler/enable stretch and asynchronous reset.
module tb_pwm_bank;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena   = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] addr  = 4'h0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic [7:0] pwm;
  logic       tick;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pwm_bank #(
    .NUM_CH(8),
    .CNT_W (8),
    .PRE_W (4)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_ena        (ena),
    .i_reg_wr_en  (wr_en),
    .i_reg_addr   (addr),
    .i_reg_wdata  (wdata),
    .o_reg_rdata  (rdata),
    .o_pwm_out    (pwm),
    .o_period_tick(tick)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ena   = 1'b1;
    wr_en = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  // Bounded wait for the next period_tick; an expired bound counts as a failure.
  task automatic wait_tick(input int bound, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tick && n < bound);
    checks++;
    if (!tick) begin
      errors++;
      $display("FAIL wait_tick: no period_tick within %0d cycles", bound);
    end
  endtask

  task automatic test_reset();
    int nt, bad;
    int t [2];
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (pwm !== 8'h00) begin errors++; $display("FAIL reset_pwm: got %h want 00", pwm); end
    checks++;
    if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
    for (int a = 0; a < 5; a++) begin
      addr = 4'(a);
      #1;
      checks++;
      if (rdata !== 8'h00) begin
        errors++; $display("FAIL reset_rdata[%0d]: got %h want 00", a, rdata);
      end
    end
    cyc();
    rst_n = 1'b1;
    nt = 0; bad = 0; t[0] = 0; t[1] = 0;
    for (int i = 1; i <= 600; i++) begin
      cyc();
      if (pwm !== 8'h00) bad++;
      if (tick === 1'b1) begin
        if (nt < 2) t[nt] = i;
        nt++;
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL idle_pwm: got %0d nonzero samples want 0", bad); end
    checks++;
    if (nt != 2) begin errors++; $display("FAIL idle_ticks: got %0d want 2", nt); end
    checks++;
    if (t[0] != 256) begin errors++; $display("FAIL first_tick: got %0d want 256", t[0]); end
    checks++;
    if (t[1] - t[0] != 256) begin
      errors++; $display("FAIL tick_spacing: got %0d want 256", t[1] - t[0]);
    end
  endtask

  task automatic test_pwm_basic();
    int n, bad, highs;
    do_reset();
    wr(4'h0, 8'h01);
    wr(4'h1, 8'h01);
    wr(4'h4, 8'd64);
    addr = 4'h0; #1;
    checks++;
    if (rdata !== 8'h01) begin errors++; $display("FAIL rd_en: got %h want 01", rdata); end
    addr = 4'h4; #1;
    checks++;
    if (rdata !== 8'd64) begin errors++; $display("FAIL rd_duty0: got %0d want 64", rdata); end
    addr = 4'hC; #1;
    checks++;
    if (rdata !== 8'h00) begin errors++; $display("FAIL rd_unmapped: got %h want 00", rdata); end
    n = 0; bad = 0;
    do begin
      cyc();
      n++;
      if (pwm[0] !== 1'b0) bad++;
    end while (!tick && n < 600);
    checks++;
    if (tick !== 1'b1) begin errors++; $display("FAIL basic_tick: none within 600 cycles"); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL basic_prelow: got %0d high samples want 0", bad); end
    highs = 0;
    for (int s = 1; s <= 256; s++) begin
      cyc();
      if (pwm[0] === 1'b1) highs++;
      if (s == 1) begin
        checks++;
        if (pwm[0] !== 1'b1) begin errors++; $display("FAIL basic_rise: got %b want 1", pwm[0]); end
      end
      if (s == 65) begin
        checks++;
        if (pwm[0] !== 1'b0) begin errors++; $display("FAIL basic_fall: got %b want 0", pwm[0]); end
      end
      if (s == 256) begin
        checks++;
        if (tick !== 1'b1) begin errors++; $display("FAIL basic_period: tick got %b want 1", tick); end
      end
    end
    checks++;
    if (highs != 64) begin errors++; $display("FAIL basic_duty64: got %0d highs want 64", highs); end
  endtask

  task automatic test_duty_extremes();
    int n, h1, h2;
    do_reset();
    wr(4'h0, 8'h06);
    wr(4'h1, 8'h06);
    wr(4'h5, 8'd0);
    wr(4'h6, 8'd255);
    wait_tick(600, n);
    h1 = 0; h2 = 0;
    for (int s = 1; s <= 256; s++) begin
      cyc();
      if (pwm[1] === 1'b1) h1++;
      if (pwm[2] === 1'b1) h2++;
    end
    checks++;
    if (h1 != 0) begin errors++; $display("FAIL duty0_ch1: got %0d highs want 0", h1); end
    checks++;
    if (h2 != 256) begin errors++; $display("FAIL duty255_ch2: got %0d highs want 256", h2); end
    wr(4'h2, 8'h08);
    wr(4'h1, 8'h00);
    wr(4'h0, 8'h08);
    checks++;
    if (pwm !== 8'h00) begin errors++; $display("FAIL static_before: got %h want 00", pwm); end
    cyc();
    checks++;
    if (pwm !== 8'h08) begin errors++; $display("FAIL static_level: got %h want 08", pwm); end
  endtask

  task automatic test_duty_update();
    int n;
    int highs [4];
    int ticks;
    do_reset();
    wr(4'h0, 8'h01);
    wr(4'h1, 8'h01);
    wr(4'h4, 8'd64);
    wait_tick(600, n);
    for (int p = 0; p < 4; p++) highs[p] = 0;
    ticks = 0;
    // Sample s is taken in the cycle where the counter holds s mod 256.
    for (int s = 1; s <= 1024; s++) begin
      cyc();
      if (pwm[0] === 1'b1) highs[(s - 1) / 256]++;
      if (tick === 1'b1 && (s % 256) == 0) ticks++;
      if (s == 100) begin wr_en = 1'b1; addr = 4'h4; wdata = 8'd192; end
      if (s == 101) wr_en = 1'b0;
      if (s == 511) begin wr_en = 1'b1; addr = 4'h4; wdata = 8'd32; end
      if (s == 512) wr_en = 1'b0;
    end
    checks++;
    if (highs[0] != 64) begin errors++; $display("FAIL upd_p0: got %0d want 64", highs[0]); end
    checks++;
    if (highs[1] != 192) begin errors++; $display("FAIL upd_p1: got %0d want 192", highs[1]); end
    checks++;
    if (highs[2] != 192) begin errors++; $display("FAIL upd_bnd_p2: got %0d want 192", highs[2]); end
    checks++;
    if (highs[3] != 32) begin errors++; $display("FAIL upd_bnd_p3: got %0d want 32", highs[3]); end
    checks++;
    if (ticks != 4) begin errors++; $display("FAIL upd_ticks: got %0d want 4", ticks); end
  endtask

  task automatic test_prescale_ena();
    int n, s, zeros_off, zeros_on;
    do_reset();
    wr(4'h0, 8'h01);
    wr(4'h1, 8'h01);
    wr(4'h4, 8'd255);
    wr(4'h3, 8'd3);
    wait_tick(3000, n);
    wait_tick(3000, n);
    checks++;
    if (n != 1024) begin errors++; $display("FAIL pre3_spacing: got %0d want 1024", n); end
    s = 0; zeros_off = 0; zeros_on = 0;
    do begin
      cyc();
      s++;
      if (pwm[0] !== 1'b1) begin
        if (s > 300 && s <= 350) zeros_off++;
        else zeros_on++;
      end
      if (s == 300) ena = 1'b0;
      if (s == 350) ena = 1'b1;
    end while (!tick && s < 3000);
    checks++;
    if (s != 1074) begin errors++; $display("FAIL ena_spacing: got %0d want 1074", s); end
    checks++;
    if (zeros_off != 50) begin errors++; $display("FAIL ena_low_out: got %0d zeros want 50", zeros_off); end
    checks++;
    if (zeros_on != 0) begin errors++; $display("FAIL ena_high_out: got %0d zeros want 0", zeros_on); end
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    wr(4'h0, 8'h01);
    wr(4'h1, 8'h01);
    wr(4'h4, 8'd200);
    wait_tick(600, n);
    repeat (130) cyc();
    checks++;
    if (pwm[0] !== 1'b1) begin errors++; $display("FAIL arst_active: got %b want 1", pwm[0]); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pwm !== 8'h00) begin errors++; $display("FAIL arst_immediate: got %h want 00", pwm); end
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a);
      #1;
      checks++;
      if (rdata !== 8'h00) begin
        errors++; $display("FAIL arst_rdata[%0d]: got %h want 00", a, rdata);
      end
    end
    repeat (5) cyc();
    checks++;
    if (pwm !== 8'h00) begin errors++; $display("FAIL arst_after: got %h want 00", pwm); end
  endtask

  initial begin
    test_reset();
    test_pwm_basic();
    test_duty_extremes();
    test_duty_update();
    test_prescale_ena();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
